seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_pkg.sv | 20 ++
 rtl/seq_multiplier.sv | 116 +++++++++++
 tb/tb_seq_multiplier.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared processor package: FSM state encoding and default datapath width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seq_multiplier_pkg;

   // Datapath width used by every block in the multi-cycle datapath.
   localparam int SEQ_WIDTH = 16;

   // FSM state encoding shared with the control unit.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (signed or unsigned), one partial product per cycle.
// Latency: WIDTH edges from the accepting edge to the one-cycle done pulse.
// Backpressure: none; start is ignored while busy, the caller waits on done.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   start, signed_mode  request and operand interpretation, sampled in IDLE/DONE
//   op_a, op_b          multiplicand / multiplier, sampled with start
//   busy                high while the iteration is running
//   done                one-cycle pulse when the product has been registered
//   result_lo/result_hi product halves, updated only on completion
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mul_state_t         state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial sum, remaining multiplier bits}
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               neg_q, neg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] res_q, res_d;

   logic [WIDTH:0]     sum;               // one extra bit keeps the carry of the add
   logic [2*WIDTH-1:0] shifted;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   always_comb begin
      // Two's-complement magnitude; 0x8000 maps to itself, which is correct when
      // read as unsigned, so the most negative operand needs no special case.
      mag_a = (signed_mode && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
      mag_b = (signed_mode && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      // Carry becomes the new MSB; the consumed multiplier bit falls off the bottom.
      shifted = {sum, acc_q[WIDTH-1:1]};
      product = neg_q ? (~shifted + (2*WIDTH)'(1)) : shifted;
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      res_d   = res_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mcand_d = mag_a;
               // Upper half is the cleared accumulator; lower half holds the multiplier.
               acc_d   = {{WIDTH{1'b0}}, mag_b};
               neg_d   = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               cnt_d   = '0;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d = shifted;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               res_d   = product;
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // Decoded from registered state only; no input reaches an output combinationally.
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign result_lo = res_q[WIDTH-1:0];
   assign result_hi = res_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed vectors, hand-computed products.
module tb_seq_multiplier;

   localparam int W   = 16;
   localparam int LAT = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic          signed_mode = 1'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  result_lo;
   logic [W-1:0]  result_hi;

   seq_multiplier #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .signed_mode (signed_mode),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .result_lo   (result_lo),
      .result_hi   (result_hi)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int busy_run = 0;

   logic [2*W-1:0] exp_q[$];
   int             acc_cyc_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops and compares whenever the DUT signals completion.
   always @(negedge CLK) begin
      if (RST) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            done_cnt++;
            check("done_busy_overlap", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
            end else begin
               logic [2*W-1:0] e;
               int a;
               e = exp_q.pop_front();
               a = acc_cyc_q.pop_front();
               check("product", 64'({result_hi, result_lo}), 64'(e));
               check("latency", 64'(cyc - a), 64'(LAT));
               check("busy_cycles", 64'(busy_run), 64'(LAT));
            end
            busy_run = 0;
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic push, input logic [2*W-1:0] e);
      @(negedge CLK);
      start = 1'b1; op_a = a; op_b = b; signed_mode = s;
      @(posedge CLK);
      #1;
      if (push) begin
         exp_q.push_back(e);
         acc_cyc_q.push_back(cyc);
      end
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n0;
      int i;
      n0 = done_cnt;
      i = 0;
      while (done_cnt == n0 && i < 60) begin
         @(negedge CLK);
         #1;
         i++;
      end
      total++;
      if (done_cnt == n0) begin
         bad++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected one", i);
      end
   endtask

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           s;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n0;

      vecs[0] = '{a: 16'h1234, b: 16'h0010, s: 1'b0, p: 32'h0001_2340};
      vecs[1] = '{a: 16'hFFFD, b: 16'h0005, s: 1'b1, p: 32'hFFFF_FFF1};
      vecs[2] = '{a: 16'h8000, b: 16'h8000, s: 1'b1, p: 32'h4000_0000};
      vecs[3] = '{a: 16'h7FFF, b: 16'h8000, s: 1'b1, p: 32'hC000_8000};
      vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, s: 1'b1, p: 32'h0000_0001};
      vecs[5] = '{a: 16'hABCD, b: 16'h0000, s: 1'b0, p: 32'h0000_0000};

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_lo",   64'(result_lo), 64'd0);
      check("rst_hi",   64'(result_hi), 64'd0);
      RST = 1'b0;

      // Unsigned basics
      issue(16'd3, 16'd5, 1'b0, 1'b1, 32'h0000_000F);
      wait_done();
      issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFE_0001);
      wait_done();

      // Reset mid-RUN: outputs clear immediately, no done for the aborted op
      issue(16'd3, 16'd5, 1'b0, 1'b0, '0);
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_lo",   64'(result_lo), 64'd0);
      check("abort_hi",   64'(result_hi), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      n0 = done_cnt;
      repeat (25) @(negedge CLK);
      check("abort_no_done", 64'(done_cnt), 64'(n0));

      // Signed and boundary vectors
      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].p);
         wait_done();
      end

      // start during RUN is ignored
      issue(16'd7, 16'd9, 1'b0, 1'b1, 32'h0000_003F);
      repeat (3) @(negedge CLK);
      start = 1'b1; op_a = 16'd2; op_b = 16'd2; signed_mode = 1'b0;
      @(negedge CLK);
      start = 1'b0;
      wait_done();

      // Back-to-back: start held through DONE
      @(negedge CLK);
      start = 1'b1; op_a = 16'h00FF; op_b = 16'h0101; signed_mode = 1'b0;
      @(posedge CLK);
      #1;
      exp_q.push_back(32'h0000_FFFF);
      acc_cyc_q.push_back(cyc);
      @(negedge CLK);
      op_a = 16'h0100; op_b = 16'h0100;   // second op, presented while the first runs
      begin
         int i;
         i = 0;
         while (!done && i < 40) begin
            @(negedge CLK);
            i++;
         end
         total++;
         if (!done) begin
            bad++;
            $display("FAIL b2b_first_timeout: got no done within %0d cycles", i);
         end
      end
      @(posedge CLK);
      #1;
      exp_q.push_back(32'h0001_0000);
      acc_cyc_q.push_back(cyc);
      check("b2b_accept_busy", 64'(busy), 64'd1);
      @(negedge CLK);
      start = 1'b0;
      repeat (5) @(negedge CLK);
      check("b2b_hold_lo", 64'(result_lo), 64'h0000_FFFF);
      check("b2b_hold_hi", 64'(result_hi), 64'h0000_0000);
      wait_done();

      // Drain: any stray done would hit an empty scoreboard
      repeat (30) @(negedge CLK);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected end of test");
      $fatal(1, "timeout");
   end

endmodule
